// File: rtl/cpri_pkg_hdr_parser.sv
// cpri_pkg_hdr_parser: per-link CPRI uplink packet framer.
// Finds packet boundaries on the receive word stream and decodes the header
// word. Only PUSCH payload is forwarded, marked with start/end flags, and
// short or overlong packets raise error pulses.
// Optional feature macro: PKG_ERR_CNT_EN adds saturating 16-bit short/long
// error counters with a synchronous clear input.
module cpri_pkg_hdr_parser #(
  parameter int PKG_WORDS  = 48,
  parameter int PUSCH_TYPE = 8
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [63:0]                  i_cpri_rx_data,
  input  logic                         i_cpri_rx_vld,
`ifdef PKG_ERR_CNT_EN
  input  logic                         i_cnt_clr,
  output logic [15:0]                  o_short_cnt,
  output logic [15:0]                  o_long_cnt,
`endif
  output logic                         o_hdr_vld,
  output logic [3:0]                   o_pkg_type,
  output logic [7:0]                   o_prb0_idx,
  output logic [7:0]                   o_prb1_idx,
  output logic [6:0]                   o_slot_idx,
  output logic [3:0]                   o_symb_idx,
  output logic [3:0]                   o_ant0_idx,
  output logic [3:0]                   o_ant1_idx,
  output logic [63:0]                  o_data,
  output logic                         o_data_vld,
  output logic                         o_sop,
  output logic                         o_eop,
  output logic [$clog2(PKG_WORDS)-1:0] o_word_idx,
  output logic                         o_err_short,
  output logic                         o_err_long
);

  localparam int CW = $clog2(PKG_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(PKG_WORDS - 1);
  localparam logic [3:0]    PUSCH_T  = 4'(PUSCH_TYPE);

  typedef enum logic [1:0] {IDLE, PAYLOAD, TAIL, DROP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          long_seen, long_seen_nxt;
  logic          vld_p1;
  logic          hdr_start;

  logic          hdr_vld_nxt;
  logic          data_vld_nxt;
  logic          sop_nxt;
  logic          eop_nxt;
  logic          err_short_nxt;
  logic          err_long_nxt;

  // A header is a valid word following an idle cycle. vld_p1 resets high so a
  // burst already running at reset release is never mistaken for a header.
  assign hdr_start = i_cpri_rx_vld & ~vld_p1;

  // State register, payload word counter and edge-detect history
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      long_seen <= 1'b0;
      vld_p1    <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      long_seen <= long_seen_nxt;
      vld_p1    <= i_cpri_rx_vld;
    end
  end

  // Next-state logic and next-cycle output strobes
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    long_seen_nxt = long_seen;
    hdr_vld_nxt   = 1'b0;
    data_vld_nxt  = 1'b0;
    sop_nxt       = 1'b0;
    eop_nxt       = 1'b0;
    err_short_nxt = 1'b0;
    err_long_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (hdr_start) begin
          hdr_vld_nxt   = 1'b1;
          cnt_nxt       = '0;
          long_seen_nxt = 1'b0;
          state_nxt     = (i_cpri_rx_data[39:36] == PUSCH_T) ? PAYLOAD : DROP;
        end
      end
      PAYLOAD: begin
        if (i_cpri_rx_vld) begin
          data_vld_nxt = 1'b1;
          sop_nxt      = (cnt == '0);
          eop_nxt      = (cnt == LAST_IDX);
          if (cnt == LAST_IDX) begin
            state_nxt = TAIL;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          // Burst ended early; forwarded words stay, no end marker follows.
          err_short_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      TAIL: begin
        if (!i_cpri_rx_vld) begin
          state_nxt = IDLE;
        end else if (!long_seen) begin
          err_long_nxt  = 1'b1;
          long_seen_nxt = 1'b1;
        end
      end
      DROP: begin
        if (!i_cpri_rx_vld) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs; header fields and payload data hold between strobes
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_hdr_vld   <= 1'b0;
      o_pkg_type  <= '0;
      o_prb0_idx  <= '0;
      o_prb1_idx  <= '0;
      o_slot_idx  <= '0;
      o_symb_idx  <= '0;
      o_ant0_idx  <= '0;
      o_ant1_idx  <= '0;
      o_data      <= '0;
      o_data_vld  <= 1'b0;
      o_sop       <= 1'b0;
      o_eop       <= 1'b0;
      o_word_idx  <= '0;
      o_err_short <= 1'b0;
      o_err_long  <= 1'b0;
    end else begin
      o_hdr_vld   <= hdr_vld_nxt;
      o_data_vld  <= data_vld_nxt;
      o_sop       <= sop_nxt;
      o_eop       <= eop_nxt;
      o_err_short <= err_short_nxt;
      o_err_long  <= err_long_nxt;
      if (hdr_vld_nxt) begin
        o_pkg_type <= i_cpri_rx_data[39:36];
        o_prb0_idx <= i_cpri_rx_data[35:28];
        o_prb1_idx <= i_cpri_rx_data[27:20];
        o_slot_idx <= i_cpri_rx_data[18:12];
        o_symb_idx <= i_cpri_rx_data[11:8];
        o_ant0_idx <= i_cpri_rx_data[7:4];
        o_ant1_idx <= i_cpri_rx_data[3:0];
      end
      if (data_vld_nxt) begin
        o_data     <= i_cpri_rx_data;
        o_word_idx <= cnt;
      end
    end
  end

`ifdef PKG_ERR_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating error counters; clear wins over a same-cycle increment
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_short_cnt <= '0;
      o_long_cnt  <= '0;
    end else if (i_cnt_clr) begin
      o_short_cnt <= '0;
      o_long_cnt  <= '0;
    end else begin
      if (o_err_short) o_short_cnt <= sat_inc(o_short_cnt);
      if (o_err_long)  o_long_cnt  <= sat_inc(o_long_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_cpri_pkg_hdr_parser.sv
// Testbench for cpri_pkg_hdr_parser (default PKG_WORDS=48, PUSCH_TYPE=8).
// Expected headers and payload words are queued as stimulus is driven and
// compared as the DUT emits them; error pulses are tallied and checked per test.
// Define PKG_ERR_CNT_EN to also exercise the error counters.
module tb_cpri_pkg_hdr_parser;

  localparam int PW = 48;
  localparam int IW = $clog2(PW);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [63:0]   rx_data = '0;
  logic          rx_vld = 1'b0;
`ifdef PKG_ERR_CNT_EN
  logic          cnt_clr = 1'b0;
  logic [15:0]   short_cnt;
  logic [15:0]   long_cnt;
`endif
  logic          hdr_vld;
  logic [3:0]    pkg_type;
  logic [7:0]    prb0_idx, prb1_idx;
  logic [6:0]    slot_idx;
  logic [3:0]    symb_idx, ant0_idx, ant1_idx;
  logic [63:0]   data;
  logic          data_vld, sop, eop;
  logic [IW-1:0] word_idx;
  logic          err_short, err_long;

  typedef struct packed {
    logic [63:0]   d;
    logic [IW-1:0] idx;
    logic          sop;
    logic          eop;
  } exp_t;

  exp_t        dq[$];
  logic [38:0] hq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          seen_short = 0;
  int          seen_long  = 0;
  logic        hdr_prev = 1'b0;

  cpri_pkg_hdr_parser #(.PKG_WORDS(PW), .PUSCH_TYPE(8)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_cpri_rx_data (rx_data),
    .i_cpri_rx_vld  (rx_vld),
`ifdef PKG_ERR_CNT_EN
    .i_cnt_clr      (cnt_clr),
    .o_short_cnt    (short_cnt),
    .o_long_cnt     (long_cnt),
`endif
    .o_hdr_vld      (hdr_vld),
    .o_pkg_type     (pkg_type),
    .o_prb0_idx     (prb0_idx),
    .o_prb1_idx     (prb1_idx),
    .o_slot_idx     (slot_idx),
    .o_symb_idx     (symb_idx),
    .o_ant0_idx     (ant0_idx),
    .o_ant1_idx     (ant1_idx),
    .o_data         (data),
    .o_data_vld     (data_vld),
    .o_sop          (sop),
    .o_eop          (eop),
    .o_word_idx     (word_idx),
    .o_err_short    (err_short),
    .o_err_long     (err_long)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Header word with junk in the ignored bits [63:40] and [19].
  function automatic logic [63:0] mk_hdr(input logic [3:0] t, input logic [7:0] p0,
                                         input logic [7:0] p1, input logic [6:0] s,
                                         input logic [3:0] sy, input logic [3:0] a0,
                                         input logic [3:0] a1);
    return {24'hA5C3E1, t, p0, p1, 1'b1, s, sy, a0, a1};
  endfunction

  task automatic drive(input logic [63:0] d, input logic v);
    @(posedge clk);
    #1;
    rx_data = d;
    rx_vld  = v;
  endtask

  // Header followed by n payload words; fwd selects whether the words are
  // expected at the output (first PW only), gap adds a trailing idle cycle.
  task automatic drive_pkt(input logic [63:0] h, input bit fwd, input int n, input bit gap);
    logic [63:0] d;
    drive(h, 1'b1);
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      if (fwd && i < PW) dq.push_back({d, IW'(i), (i == 0), (i == PW - 1)});
      drive(d, 1'b1);
    end
    if (gap) drive(64'h0, 1'b0);
  endtask

  // Scoreboard consumer: compares every header and payload strobe
  task automatic run_monitor();
    exp_t        e;
    logic [38:0] eh;
    forever begin
      @(negedge clk);
      if (hdr_vld === 1'b1) begin
        n_checks++;
        if (hq.size() == 0) begin
          n_fail++;
          $display("FAIL hdr_unexpected: got type=%0d at %0t, required no header", pkg_type, $time);
        end else begin
          eh = hq.pop_front();
          if ({pkg_type, prb0_idx, prb1_idx, slot_idx, symb_idx, ant0_idx, ant1_idx} !== eh) begin
            n_fail++;
            $display("FAIL hdr_fields: got %h required %h",
                     {pkg_type, prb0_idx, prb1_idx, slot_idx, symb_idx, ant0_idx, ant1_idx}, eh);
          end
        end
      end
      if (data_vld === 1'b1) begin
        n_checks++;
        if (dq.size() == 0) begin
          n_fail++;
          $display("FAIL data_unexpected: got idx=%0d data=%h, required no data", word_idx, data);
        end else begin
          e = dq.pop_front();
          if ({data, word_idx, sop, eop} !== e) begin
            n_fail++;
            $display("FAIL data_word: got d=%h idx=%0d sop=%b eop=%b required d=%h idx=%0d sop=%b eop=%b",
                     data, word_idx, sop, eop, e.d, e.idx, e.sop, e.eop);
          end
        end
        if (sop === 1'b1) begin
          n_checks++;
          if (hdr_prev !== 1'b1) begin
            n_fail++;
            $display("FAIL sop_order: got sop without header one cycle before, required header then sop");
          end
        end
      end
      if (err_short === 1'b1) seen_short++;
      if (err_long === 1'b1)  seen_long++;
      hdr_prev = hdr_vld;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({hdr_vld, pkg_type, prb0_idx, prb1_idx, slot_idx, symb_idx, ant0_idx, ant1_idx,
         data, data_vld, sop, eop, word_idx, err_short, err_long} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero outputs during reset, required all 0");
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({hdr_vld, data_vld, sop, eop, word_idx, err_short, err_long} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got nonzero control outputs, required 0");
    end
  endtask

  task automatic test_pusch();
    int s0 = seen_short, l0 = seen_long;
    hq.push_back({4'd8, 8'h01, 8'h23, 7'h45, 4'd6, 4'd1, 4'd2});
    drive_pkt(64'h0000_0080_1234_5612, 1'b1, PW, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (dq.size() != 0 || hq.size() != 0) begin
      n_fail++;
      $display("FAIL pusch_drain: got %0d data / %0d hdr outstanding, required 0", dq.size(), hq.size());
    end
    n_checks++;
    if (seen_short != s0 || seen_long != l0) begin
      n_fail++;
      $display("FAIL pusch_errors: got short=%0d long=%0d, required 0", seen_short - s0, seen_long - l0);
    end
  endtask

  task automatic test_non_pusch();
    int s0 = seen_short, l0 = seen_long;
    hq.push_back({4'd4, 8'h9A, 8'h5C, 7'h11, 4'd3, 4'd7, 4'd9});
    drive_pkt(mk_hdr(4'd4, 8'h9A, 8'h5C, 7'h11, 4'd3, 4'd7, 4'd9), 1'b0, PW, 1'b1);
    // Dropped packets never flag length errors, even when short.
    hq.push_back({4'd15, 8'hFF, 8'h00, 7'h7F, 4'd15, 4'd0, 4'd15});
    drive_pkt(mk_hdr(4'd15, 8'hFF, 8'h00, 7'h7F, 4'd15, 4'd0, 4'd15), 1'b0, 5, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (dq.size() != 0 || hq.size() != 0) begin
      n_fail++;
      $display("FAIL non_pusch_drain: got %0d data / %0d hdr outstanding, required 0", dq.size(), hq.size());
    end
    n_checks++;
    if (seen_short != s0 || seen_long != l0) begin
      n_fail++;
      $display("FAIL non_pusch_errors: got short=%0d long=%0d, required 0", seen_short - s0, seen_long - l0);
    end
  endtask

  task automatic test_short();
    int s0 = seen_short, l0 = seen_long;
    hq.push_back({4'd8, 8'h10, 8'h20, 7'h30, 4'd4, 4'd5, 4'd6});
    drive_pkt(mk_hdr(4'd8, 8'h10, 8'h20, 7'h30, 4'd4, 4'd5, 4'd6), 1'b1, 20, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (seen_short != s0 + 1 || seen_long != l0) begin
      n_fail++;
      $display("FAIL short_errors: got short=%0d long=%0d, required short=1 long=0",
               seen_short - s0, seen_long - l0);
    end
    hq.push_back({4'd8, 8'hAB, 8'hCD, 7'h01, 4'd13, 4'd14, 4'd3});
    drive_pkt(mk_hdr(4'd8, 8'hAB, 8'hCD, 7'h01, 4'd13, 4'd14, 4'd3), 1'b1, PW, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (dq.size() != 0 || hq.size() != 0 || seen_short != s0 + 1) begin
      n_fail++;
      $display("FAIL short_recover: got %0d data / %0d hdr outstanding, short=%0d, required 0/0/1",
               dq.size(), hq.size(), seen_short - s0);
    end
  endtask

  task automatic test_long();
    int s0 = seen_short, l0 = seen_long;
    hq.push_back({4'd8, 8'h55, 8'hAA, 7'h2A, 4'd9, 4'd8, 4'd7});
    drive_pkt(mk_hdr(4'd8, 8'h55, 8'hAA, 7'h2A, 4'd9, 4'd8, 4'd7), 1'b1, PW + 2, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (seen_long != l0 + 1 || seen_short != s0) begin
      n_fail++;
      $display("FAIL long_errors: got long=%0d short=%0d, required long=1 short=0",
               seen_long - l0, seen_short - s0);
    end
    n_checks++;
    if (dq.size() != 0 || hq.size() != 0) begin
      n_fail++;
      $display("FAIL long_drain: got %0d data / %0d hdr outstanding, required 0", dq.size(), hq.size());
    end
  endtask

  task automatic test_reset_mid();
    int s0 = seen_short, l0 = seen_long;
    logic [63:0] d;
    hq.push_back({4'd8, 8'h0F, 8'hF0, 7'h3C, 4'd2, 4'd3, 4'd4});
    drive(mk_hdr(4'd8, 8'h0F, 8'hF0, 7'h3C, 4'd2, 4'd3, 4'd4), 1'b1);
    for (int i = 0; i <= 10; i++) begin
      d = {$urandom, $urandom};
      dq.push_back({d, IW'(i), (i == 0), 1'b0});
      drive(d, 1'b1);
    end
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({hdr_vld, pkg_type, prb0_idx, prb1_idx, slot_idx, symb_idx, ant0_idx, ant1_idx,
         data, data_vld, sop, eop, word_idx, err_short, err_long} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got nonzero outputs right after reset, required all 0");
    end
    for (int i = 0; i < 3; i++) drive({$urandom, $urandom}, 1'b1);
    n_checks++;
    if ({data_vld, hdr_vld, word_idx, data} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_hold: got nonzero outputs while in reset, required 0");
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) drive({$urandom, $urandom}, 1'b1);
    drive(64'h0, 1'b0);
    hq.push_back({4'd8, 8'h77, 8'h66, 7'h55, 4'd1, 4'd2, 4'd3});
    drive_pkt(mk_hdr(4'd8, 8'h77, 8'h66, 7'h55, 4'd1, 4'd2, 4'd3), 1'b1, PW, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (dq.size() != 0 || hq.size() != 0 || seen_short != s0 || seen_long != l0) begin
      n_fail++;
      $display("FAIL reset_mid_after: got %0d data / %0d hdr outstanding, short=%0d long=%0d, required 0",
               dq.size(), hq.size(), seen_short - s0, seen_long - l0);
    end
  endtask

  task automatic test_back_to_back();
    int s0 = seen_short, l0 = seen_long;
    // Single idle cycle between packets: both are parsed.
    hq.push_back({4'd8, 8'h01, 8'h02, 7'h03, 4'd4, 4'd5, 4'd6});
    drive_pkt(mk_hdr(4'd8, 8'h01, 8'h02, 7'h03, 4'd4, 4'd5, 4'd6), 1'b1, PW, 1'b1);
    hq.push_back({4'd8, 8'h11, 8'h12, 7'h13, 4'd14, 4'd15, 4'd0});
    drive_pkt(mk_hdr(4'd8, 8'h11, 8'h12, 7'h13, 4'd14, 4'd15, 4'd0), 1'b1, PW, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dq.size() != 0 || hq.size() != 0 || seen_short != s0 || seen_long != l0) begin
      n_fail++;
      $display("FAIL gap_one_cycle: got %0d data / %0d hdr outstanding, short=%0d long=%0d, required 0",
               dq.size(), hq.size(), seen_short - s0, seen_long - l0);
    end
    // No gap: the second packet is swallowed as overlength.
    hq.push_back({4'd8, 8'h21, 8'h22, 7'h23, 4'd2, 4'd4, 4'd8});
    drive_pkt(mk_hdr(4'd8, 8'h21, 8'h22, 7'h23, 4'd2, 4'd4, 4'd8), 1'b1, PW, 1'b0);
    drive_pkt(mk_hdr(4'd8, 8'h31, 8'h32, 7'h33, 4'd3, 4'd6, 4'd9), 1'b0, PW, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (dq.size() != 0 || hq.size() != 0 || seen_long != l0 + 1 || seen_short != s0) begin
      n_fail++;
      $display("FAIL no_gap_absorb: got %0d data / %0d hdr outstanding, long=%0d short=%0d, required 0/0/1/0",
               dq.size(), hq.size(), seen_long - l0, seen_short - s0);
    end
  endtask

`ifdef PKG_ERR_CNT_EN
  task automatic test_err_cnt();
    logic [63:0] h;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    h = mk_hdr(4'd8, 8'h01, 8'h01, 7'h01, 4'd1, 4'd1, 4'd1);
    for (int k = 0; k < 3; k++) begin
      hq.push_back({4'd8, 8'h01, 8'h01, 7'h01, 4'd1, 4'd1, 4'd1});
      drive_pkt(h, 1'b1, 4, 1'b1);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (short_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL short_cnt: got %0d required 3", short_cnt);
    end
    hq.push_back({4'd8, 8'h01, 8'h01, 7'h01, 4'd1, 4'd1, 4'd1});
    drive_pkt(h, 1'b1, 4, 1'b1);
    @(posedge clk);
    #1 cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (short_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL short_cnt_clr: got %0d required 0", short_cnt);
    end
  endtask
`endif

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_pusch();
    test_non_pusch();
    test_short();
    test_long();
    test_reset_mid();
    test_back_to_back();
`ifdef PKG_ERR_CNT_EN
    test_err_cnt();
`endif
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
